frac_search_ctrl: RTL and testbench

//  Sequencer for frac_search. Accepts 8x8 block jobs over a valid/ready request port.
//  For each job it reads current and original rows from two synchronous line memories.
//  It drives frac_search with the required row/skew protocol, captures sad_out/mvx/mvy,
//  and returns them with the job tag on a valid/ready response port. One job in flight.

---
 rtl/frac_search_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frac_search_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_search_ctrl.sv
// Job sequencer for frac_search: reads the current and original 8x8 block rows,
// drives the row/skew protocol, and returns the captured result with the job tag.
module frac_search_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int TAG_W    = 4,
  parameter int RSLT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              cur_rd_en,
  output logic [ADDR_W-1:0] cur_rd_addr,
  input  logic [63:0]       cur_rd_data,
  output logic              org_rd_en,
  output logic [ADDR_W-1:0] org_rd_addr,
  input  logic [63:0]       org_rd_data,
  output logic              fs_ready,
  output logic [63:0]       fs_cur_pix,
  output logic [47:0]       fs_org_pix,
  input  logic [11:0]       fs_sad,
  input  logic [2:0]        fs_mvx,
  input  logic [2:0]        fs_mvy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [11:0]       rsp_sad,
  output logic [2:0]        rsp_mvx,
  output logic [2:0]        rsp_mvy,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [15:0]       blk_cnt
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready high
  // PRIME | first current-row read issued
  // FEED  | 8 rows streamed to frac_search, k = row index
  // WAIT  | result latency countdown, capture on terminal count
  // HOLD  | result presented until rsp handshake
  // GAP   | one idle cycle so frac_search drops back to its idle state
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int WC_W = (RSLT_LAT > 2) ? $clog2(RSLT_LAT) : 1;

  logic [2:0]        state, state_nx;
  logic [2:0]        k, k_nx;
  logic [WC_W-1:0]   wcnt, wcnt_nx;
  logic [ADDR_W-1:0] base_q, base_nx;
  logic [TAG_W-1:0]  tag_q, tag_nx;
  logic              rsp_valid_nx, capture, done;
  logic              feed_nx, cur_en_d, org_en_d;
  logic [ADDR_W-1:0] cur_addr_d, org_addr_d;
  logic              unused_org;

  assign fs_cur_pix = cur_rd_data;
  assign fs_org_pix = org_rd_data[55:8];
  assign unused_org = ^{org_rd_data[63:56], org_rd_data[7:0]};

  always_comb begin
    state_nx     = state;
    k_nx         = k;
    wcnt_nx      = wcnt;
    base_nx      = base_q;
    tag_nx       = tag_q;
    rsp_valid_nx = rsp_valid;
    capture      = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_nx = S_PRIME;
          base_nx  = req_base;
          tag_nx   = req_tag;
        end
      end
      S_PRIME: begin
        state_nx = S_FEED;
        k_nx     = 3'd0;
      end
      S_FEED: begin
        k_nx = k + 3'd1;
        if (k == 3'd7) begin
          state_nx = S_WAIT;
          wcnt_nx  = WC_W'(RSLT_LAT - 1);
        end
      end
      S_WAIT: begin
        if (wcnt == '0) begin
          state_nx     = S_HOLD;
          capture      = 1'b1;
          rsp_valid_nx = 1'b1;
        end else begin
          wcnt_nx = wcnt - WC_W'(1);
        end
      end
      S_HOLD: begin
        if (rsp_valid && rsp_ready) begin
          state_nx     = S_GAP;
          rsp_valid_nx = 1'b0;
          done         = 1'b1;
        end
      end
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory strobes are registered from the next state so they line up with
  // the cycle they belong to: cur row k+1 is fetched while row k is on the bus.
  always_comb begin
    feed_nx    = (state_nx == S_FEED);
    cur_en_d   = (state_nx == S_PRIME) || (feed_nx && (k_nx != 3'd7));
    org_en_d   = feed_nx && (k_nx != 3'd0) && (k_nx != 3'd7);
    cur_addr_d = '0;
    org_addr_d = '0;
    if (state_nx == S_PRIME)
      cur_addr_d = base_nx;
    else if (cur_en_d)
      cur_addr_d = base_nx + ADDR_W'(k_nx) + ADDR_W'(1);
    if (org_en_d)
      org_addr_d = base_nx + ADDR_W'(k_nx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      k           <= '0;
      wcnt        <= '0;
      base_q      <= '0;
      tag_q       <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      cur_rd_en   <= 1'b0;
      cur_rd_addr <= '0;
      org_rd_en   <= 1'b0;
      org_rd_addr <= '0;
      fs_ready    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_sad     <= '0;
      rsp_mvx     <= '0;
      rsp_mvy     <= '0;
      rsp_tag     <= '0;
      blk_cnt     <= '0;
    end else begin
      state       <= state_nx;
      k           <= k_nx;
      wcnt        <= wcnt_nx;
      base_q      <= base_nx;
      tag_q       <= tag_nx;
      req_ready   <= (state_nx == S_IDLE) && !rsp_valid_nx;
      busy        <= (state_nx != S_IDLE);
      cur_rd_en   <= cur_en_d;
      cur_rd_addr <= cur_addr_d;
      org_rd_en   <= org_en_d;
      org_rd_addr <= org_addr_d;
      fs_ready    <= feed_nx;
      rsp_valid   <= rsp_valid_nx;
      if (capture) begin
        rsp_sad <= fs_sad;
        rsp_mvx <= fs_mvx;
        rsp_mvy <= fs_mvy;
        rsp_tag <= tag_q;
      end
      if (done)
        blk_cnt <= blk_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Bench for frac_search_ctrl: line memories, a frac_search stand-in that only presents
// its result in the capture window, a golden result model, and protocol monitors.
module tb_frac_search_ctrl;
  localparam int AW  = 10;
  localparam int TW  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_base;
  logic [TW-1:0] req_tag;
  logic          cur_rd_en, org_rd_en;
  logic [AW-1:0] cur_rd_addr, org_rd_addr;
  logic [63:0]   cur_rd_data = '0, org_rd_data = '0;
  logic          fs_ready;
  logic [63:0]   fs_cur_pix;
  logic [47:0]   fs_org_pix;
  logic [11:0]   fs_sad;
  logic [2:0]    fs_mvx, fs_mvy;
  logic          rsp_valid, rsp_ready;
  logic [11:0]   rsp_sad;
  logic [2:0]    rsp_mvx, rsp_mvy;
  logic [TW-1:0] rsp_tag;
  logic          busy;
  logic [15:0]   blk_cnt;

  frac_search_ctrl #(.ADDR_W(AW), .TAG_W(TW), .RSLT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_tag(req_tag), .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr),
    .cur_rd_data(cur_rd_data), .org_rd_en(org_rd_en), .org_rd_addr(org_rd_addr),
    .org_rd_data(org_rd_data), .fs_ready(fs_ready), .fs_cur_pix(fs_cur_pix),
    .fs_org_pix(fs_org_pix), .fs_sad(fs_sad), .fs_mvx(fs_mvx), .fs_mvy(fs_mvy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sad(rsp_sad), .rsp_mvx(rsp_mvx),
    .rsp_mvy(rsp_mvy), .rsp_tag(rsp_tag), .busy(busy), .blk_cnt(blk_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [11:0] sad; logic [2:0] mvx; logic [2:0] mvy; logic [3:0] tag; } exp_t;
  typedef struct { logic cur_en; logic [9:0] cur_addr; logic org_en; logic [9:0] org_addr;
                   logic fs_rdy; logic rsp_vld; } trace_t;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  logic [63:0] cur_mem [1024];
  logic [63:0] org_mem [1024];
  exp_t        exp_q [$];
  int          acc_log [$];
  logic [3:0]  tag_log [$];
  logic [15:0] model_cnt = '0;
  int          hs_cyc = 0, last_vlen = 0, vlen = 0, run = 0;
  bit          fs_mon = 1'b1, prev_hold = 1'b0;
  logic [21:0] prev_rsp = '0;
  exp_t        e;
  trace_t      tr [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Weighted pixel sums: any misplaced row, wrong address or wrong org slice changes them.
  function automatic logic [17:0] fs_func(input logic [63:0] c [8], input logic [47:0] o [6]);
    int s = 0;
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 8; b++) s += (r + 1) * int'(c[r][8*b +: 8]);
    for (int r = 0; r < 6; r++)
      for (int b = 0; b < 6; b++) s += (r + 11) * int'(o[r][8*b +: 8]);
    return {12'(s), 3'(s % 5), 3'((s / 7) % 5)};
  endfunction

  function automatic exp_t golden(input logic [9:0] b, input logic [3:0] t);
    logic [63:0] c [8];
    logic [47:0] o [6];
    logic [17:0] r;
    logic [9:0]  a;
    exp_t        x;
    for (int i = 0; i < 8; i++) begin a = b + 10'(i); c[i] = cur_mem[a]; end
    for (int i = 0; i < 6; i++) begin a = b + 10'(i + 1); o[i] = org_mem[a][55:8]; end
    r = fs_func(c, o);
    x.sad = r[17:6]; x.mvx = r[5:3]; x.mvy = r[2:0]; x.tag = t;
    return x;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cur_rd_en) cur_rd_data <= cur_mem[cur_rd_addr];
    if (org_rd_en) org_rd_data <= org_mem[org_rd_addr];
  end

  // frac_search stand-in: result valid only in the cycle before the capture edge.
  int          fk = 0, lat = -1;
  logic [63:0] sc [8];
  logic [47:0] so [6];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fk = 0; lat = -1;
      {fs_sad, fs_mvx, fs_mvy} <= '0;
    end else begin
      if (fs_ready) begin
        sc[fk] = fs_cur_pix;
        if (fk >= 2) so[fk-2] = fs_org_pix;
        if (fk == 7) begin fk = 0; lat = 0; end else fk++;
      end else if (lat >= 0) lat++;
      if (lat == LAT - 1) {fs_sad, fs_mvx, fs_mvy} <= fs_func(sc, so);
      else                {fs_sad, fs_mvx, fs_mvy} <= 18'($urandom);
      if (lat >= LAT) lat = -1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      model_cnt = '0; run = 0; vlen = 0; prev_hold = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_log.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        tag_log.push_back(rsp_tag);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got tag 0x%0h want no response", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_sad", 64'(rsp_sad), 64'(e.sad));
          chk("rsp_mvx", 64'(rsp_mvx), 64'(e.mvx));
          chk("rsp_mvy", 64'(rsp_mvy), 64'(e.mvy));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        end
        chk("blk_cnt_at_hs", 64'(blk_cnt), 64'(model_cnt));
        model_cnt = model_cnt + 16'd1;
      end
      if (prev_hold)
        chk("rsp_stable", 64'({rsp_valid, rsp_sad, rsp_mvx, rsp_mvy, rsp_tag}), 64'({1'b1, prev_rsp}));
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_sad, rsp_mvx, rsp_mvy, rsp_tag};
      if (rsp_valid) chk("req_ready_while_rsp", 64'(req_ready), 64'd0);
      if (fs_ready) run++;
      else if (run != 0) begin
        if (fs_mon) chk("fs_ready_run", 64'(run), 64'd8);
        run = 0;
      end
      if (rsp_valid) vlen++;
      else if (vlen != 0) begin last_vlen = vlen; vlen = 0; end
    end
  end

  task automatic accept(input logic [9:0] b, input logic [3:0] t);
    int n = 0;
    req_valid = 1'b1; req_base = b; req_tag = t;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1 (tag 0x%0h)", t);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(golden(b, t));
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit rnd);
    int n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      @(posedge clk); #1;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d want 0/0", nm, busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {req_ready, cur_rd_en, cur_rd_addr, org_rd_en, org_rd_addr, fs_ready, rsp_valid,
             rsp_sad, rsp_mvx, rsp_mvy, rsp_tag, busy, blk_cnt}, 64'd0);
  endtask

  initial begin
    int s, t, n;
    tr[0]  = '{1'b1, 10'h3FC, 1'b0, 10'h000, 1'b0, 1'b0};
    tr[1]  = '{1'b1, 10'h3FD, 1'b0, 10'h000, 1'b1, 1'b0};
    tr[2]  = '{1'b1, 10'h3FE, 1'b1, 10'h3FD, 1'b1, 1'b0};
    tr[3]  = '{1'b1, 10'h3FF, 1'b1, 10'h3FE, 1'b1, 1'b0};
    tr[4]  = '{1'b1, 10'h000, 1'b1, 10'h3FF, 1'b1, 1'b0};
    tr[5]  = '{1'b1, 10'h001, 1'b1, 10'h000, 1'b1, 1'b0};
    tr[6]  = '{1'b1, 10'h002, 1'b1, 10'h001, 1'b1, 1'b0};
    tr[7]  = '{1'b1, 10'h003, 1'b1, 10'h002, 1'b1, 1'b0};
    tr[8]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0};
    tr[9]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0};
    tr[10] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0};
    tr[11] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1};
    for (int i = 0; i < 1024; i++) begin
      cur_mem[i] = {$urandom, $urandom};
      org_mem[i] = {$urandom, $urandom};
    end
    reset = 1'b1; req_valid = 1'b0; req_base = '0; req_tag = '0; rsp_ready = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk); chk_zero("reset_state");
    @(posedge clk); #1 reset = 1'b1;

    // single job
    accept(10'h010, 4'd5);
    wait_done("t1", 1'b0);
    chk("t1_rsp_valid_len", 64'(last_vlen), 64'd1);
    chk("t1_blk_cnt", 64'(blk_cnt), 64'd1);

    // address/enable trace across the top of the address space
    accept(10'h3FC, 4'd9);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("t2_cur_en[%0d]", i), 64'(cur_rd_en), 64'(tr[i].cur_en));
      if (tr[i].cur_en) chk($sformatf("t2_cur_addr[%0d]", i), 64'(cur_rd_addr), 64'(tr[i].cur_addr));
      chk($sformatf("t2_org_en[%0d]", i), 64'(org_rd_en), 64'(tr[i].org_en));
      if (tr[i].org_en) chk($sformatf("t2_org_addr[%0d]", i), 64'(org_rd_addr), 64'(tr[i].org_addr));
      chk($sformatf("t2_fs_ready[%0d]", i), 64'(fs_ready), 64'(tr[i].fs_rdy));
      chk($sformatf("t2_rsp_valid[%0d]", i), 64'(rsp_valid), 64'(tr[i].rsp_vld));
    end
    wait_done("t2", 1'b0);

    // back-to-back jobs
    s = acc_log.size();
    accept(10'h100, 4'd1);
    accept(10'h208, 4'd2);
    accept(10'h3F9, 4'd3);
    wait_done("t3", 1'b0);
    chk("t3_spacing_1_2", 64'(acc_log[s+1] - acc_log[s]), 64'd14);
    chk("t3_spacing_2_3", 64'(acc_log[s+2] - acc_log[s+1]), 64'd14);
    t = tag_log.size();
    chk("t3_order", 64'({tag_log[t-3], tag_log[t-2], tag_log[t-1]}), 64'h123);

    // long response backpressure
    rsp_ready = 1'b0;
    accept(10'h055, 4'd7);
    n = 0;
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    fork
      accept(10'h2A0, 4'd8);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("t4_req_ready_low", 64'(req_ready), 64'd0);
          chk("t4_fs_ready_low", 64'(fs_ready), 64'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    chk("t4_release_to_accept", 64'(acc_log[$] - hs_cyc), 64'd2);
    wait_done("t4", 1'b0);

    // reset in the middle of FEED
    accept(10'h123, 4'hA);
    repeat (5) @(posedge clk);
    #1 chk("t5_in_feed", 64'(fs_ready), 64'd1);
    fs_mon = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk_zero("t5_reset_low"); end
    @(posedge clk); #1 reset = 1'b1; fs_mon = 1'b1;
    accept(10'h200, 4'hB);
    wait_done("t5", 1'b0);
    chk("t5_blk_cnt", 64'(blk_cnt), 64'd1);

    // randomized jobs with random response backpressure
    for (int j = 0; j < 12; j++) begin
      accept(10'($urandom_range(0, 1023)), 4'(j));
      wait_done("rnd", 1'b1);
    end
    rsp_ready = 1'b1;

    // counter wrap
    @(posedge clk); #1;
    force dut.blk_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.blk_cnt;
    model_cnt = 16'hFFFF;
    accept(10'h3FF, 4'hC);
    wait_done("t6", 1'b0);
    chk("t6_blk_cnt_wrap", 64'(blk_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
